// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control unit.
// A Moore FSM sequences fetch/decode/execute/memory/writeback for a fixed
// instruction subset and drives the ALUOp/flag interface of the ALU. Mux
// selects, ALUOp and the memory strobes are registered from the next state.
// The handshake- and flag-dependent strobes (irwrite, pcen) and the state
// event pulses (regwrite, ovf_trap, illegal) are decoded from the current
// state, because they must react within the same cycle.
module mips_mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       z,
  input  logic       v,
  input  logic       mem_ready,
  output logic [4:0] ALUOp,
  output logic [1:0] alusrca,
  output logic [2:0] alusrcb,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       ovf_trap,
  output logic       illegal
);

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;

  // ALU operations; boolean ops carry their truth table in the low nibble
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_SLT  = 5'b00101;
  localparam logic [4:0] ALU_SLTU = 5'b00111;
  localparam logic [4:0] ALU_SLL  = 5'b01000;
  localparam logic [4:0] ALU_SRL  = 5'b01001;
  localparam logic [4:0] ALU_SRA  = 5'b01011;
  localparam logic [4:0] ALU_AND  = 5'b11000;
  localparam logic [4:0] ALU_OR   = 5'b11110;
  localparam logic [4:0] ALU_XOR  = 5'b10110;
  localparam logic [4:0] ALU_NOR  = 5'b10001;

  // Datapath mux selects
  localparam logic [1:0] SRCA_PC      = 2'b00;
  localparam logic [1:0] SRCA_REGA    = 2'b01;
  localparam logic [1:0] SRCA_SHAMT   = 2'b10;
  localparam logic [2:0] SRCB_REGB    = 3'b000;
  localparam logic [2:0] SRCB_FOUR    = 3'b001;
  localparam logic [2:0] SRCB_SEXT    = 3'b010;
  localparam logic [2:0] SRCB_SEXT_SH = 3'b011;
  localparam logic [2:0] SRCB_ZEXT    = 3'b100;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_REXEC, S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP
  } state_t;

  // Registered per-state controls
  typedef struct packed {
    logic [4:0] aluop;
    logic [1:0] alusrca;
    logic [2:0] alusrcb;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] pcsrc;
  } ctl_t;

  state_t state, next_state;
  ctl_t   ctl_q;
  logic   ovf_q;

  function automatic logic rfunct_ok(input logic [5:0] fn);
    case (fn)
      F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR,
      F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] rfunct_aluop(input logic [5:0] fn);
    case (fn)
      F_SUB:   return ALU_SUB;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_XOR:   return ALU_XOR;
      F_NOR:   return ALU_NOR;
      F_SLT:   return ALU_SLT;
      F_SLTU:  return ALU_SLTU;
      F_SLL:   return ALU_SLL;
      F_SRL:   return ALU_SRL;
      F_SRA:   return ALU_SRA;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic is_shift(input logic [5:0] fn);
    return (fn == F_SLL) || (fn == F_SRL) || (fn == F_SRA);
  endfunction

  // Control word shown while the FSM sits in state s
  function automatic ctl_t state_ctl(input state_t s, input logic [5:0] opc,
                                     input logic [5:0] fn);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memread = 1'b1;
        c.alusrca = SRCA_PC;
        c.alusrcb = SRCB_FOUR;
        c.pcsrc   = PCSRC_ALU;
      end
      S_DECODE: c.alusrcb = SRCB_SEXT_SH;   // branch target into ALUOut
      S_MEMADR: begin
        c.aluop   = ALU_ADD;
        c.alusrca = SRCA_REGA;
        c.alusrcb = SRCB_SEXT;
      end
      S_MEMRD: begin
        c.iord    = 1'b1;
        c.memread = 1'b1;
      end
      S_MEMWB: c.memtoreg = 1'b1;
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_REXEC: begin
        c.aluop   = rfunct_aluop(fn);
        c.alusrca = is_shift(fn) ? SRCA_SHAMT : SRCA_REGA;
        c.alusrcb = SRCB_REGB;
      end
      S_RWB: c.regdst = 1'b1;
      S_IEXEC: begin
        c.alusrca = SRCA_REGA;
        case (opc)
          OP_ANDI: begin c.aluop = ALU_AND; c.alusrcb = SRCB_ZEXT; end
          OP_ORI:  begin c.aluop = ALU_OR;  c.alusrcb = SRCB_ZEXT; end
          OP_SLTI: begin c.aluop = ALU_SLT; c.alusrcb = SRCB_SEXT; end
          default: begin c.aluop = ALU_ADD; c.alusrcb = SRCB_SEXT; end
        endcase
      end
      S_BRANCH: begin
        c.aluop   = ALU_SUB;
        c.alusrca = SRCA_REGA;
        c.alusrcb = SRCB_REGB;
        c.pcsrc   = PCSRC_ALUOUT;
      end
      S_JUMP: c.pcsrc = PCSRC_JUMP;
      default: ;
    endcase
    return c;
  endfunction

  // Next-state selection
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                     next_state = S_MEMADR;
          OP_RTYPE:                         next_state = rfunct_ok(funct) ? S_REXEC : S_FETCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_IEXEC;
          OP_BEQ, OP_BNE:                   next_state = S_BRANCH;
          OP_J:                             next_state = S_JUMP;
          default:                          next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWR:  if (mem_ready) next_state = S_FETCH;
      S_REXEC:  next_state = S_RWB;
      S_IEXEC:  next_state = S_IWB;
      default:  next_state = S_FETCH;   // MEMWB, RWB, IWB, BRANCH, JUMP
    endcase
  end

  // State, registered control word and captured overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      ctl_q <= state_ctl(S_FETCH, '0, '0);
      ovf_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= next_state;
      ctl_q <= state_ctl(next_state, op, funct);
      case (state)
        S_REXEC: ovf_q <= v & ((funct == F_ADD) || (funct == F_SUB));
        S_IEXEC: ovf_q <= v & (op == OP_ADDI);
        default: ovf_q <= 1'b0;
      endcase
    end
  end

  // Same-cycle strobes: handshake, branch resolution and event pulses
  always_comb begin
    irwrite  = (state == S_FETCH) & mem_ready & ~reset;
    pcen     = irwrite
             | ((state == S_BRANCH) & (z ^ (op == OP_BNE)))
             | (state == S_JUMP);
    regwrite = (state == S_MEMWB)
             | (((state == S_RWB) | (state == S_IWB)) & ~ovf_q);
    ovf_trap = ((state == S_RWB) | (state == S_IWB)) & ovf_q;
    illegal  = (state == S_DECODE) & ~(
                 (op == OP_LW)   | (op == OP_SW)   | (op == OP_BEQ)  |
                 (op == OP_BNE)  | (op == OP_ADDI) | (op == OP_ANDI) |
                 (op == OP_ORI)  | (op == OP_SLTI) | (op == OP_J)    |
                 ((op == OP_RTYPE) & rfunct_ok(funct)));
  end

  assign ALUOp    = ctl_q.aluop;
  assign alusrca  = ctl_q.alusrca;
  assign alusrcb  = ctl_q.alusrcb;
  assign iord     = ctl_q.iord;
  assign memread  = ctl_q.memread;
  assign memwrite = ctl_q.memwrite;
  assign regdst   = ctl_q.regdst;
  assign memtoreg = ctl_q.memtoreg;
  assign pcsrc    = ctl_q.pcsrc;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed, table-driven bench for the multicycle control FSM.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       z, v, mem_ready;
  logic [4:0] ALUOp;
  logic [1:0] alusrca;
  logic [2:0] alusrcb;
  logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, pcen;
  logic [1:0] pcsrc;
  logic       ovf_trap, illegal;

  int checks   = 0;
  int failures = 0;

  mips_mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .z(z), .v(v),
    .mem_ready(mem_ready), .ALUOp(ALUOp), .alusrca(alusrca), .alusrcb(alusrcb),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .pcen(pcen),
    .pcsrc(pcsrc), .ovf_trap(ovf_trap), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // One instruction run with mem_ready held high.
  // Cycle 2 fields describe the first state after DECODE; regdst/memtoreg
  // describe the last cycle and apply only to 4+ cycle instructions.
  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       z;
    logic       v;
    int         cycles;
    logic [4:0] aluop;
    logic [1:0] srca;
    logic [2:0] srcb;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    int         n_rw;
    int         n_mw;
    int         n_pcen;
    int         n_trap;
    int         n_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_fetch();
    return memread && !iord && (alusrcb == 3'b001);
  endfunction

  task automatic add_vec(input string name, input logic [5:0] o, input logic [5:0] f,
                         input logic zz, input logic vv, input int cyc,
                         input logic [4:0] aop, input logic [1:0] sa, input logic [2:0] sb,
                         input logic [1:0] ps, input logic rd, input logic mt,
                         input int rw, input int mw, input int pc, input int tr, input int il);
    vec_t t;
    t.name = name; t.op = o; t.funct = f; t.z = zz; t.v = vv; t.cycles = cyc;
    t.aluop = aop; t.srca = sa; t.srcb = sb; t.pcsrc = ps; t.regdst = rd; t.memtoreg = mt;
    t.n_rw = rw; t.n_mw = mw; t.n_pcen = pc; t.n_trap = tr; t.n_ill = il;
    vecs.push_back(t);
  endtask

  // Entered with the FSM in FETCH; leaves it in the following FETCH.
  task automatic run_vec(input vec_t t);
    int n_rw, n_mw, n_pc, n_tr, n_il;
    n_rw = 0; n_mw = 0; n_pc = 0; n_tr = 0; n_il = 0;
    op = t.op; funct = t.funct; z = t.z; v = t.v; mem_ready = 1'b1;
    for (int c = 0; c < t.cycles; c++) begin
      #1;
      if (c == 0) check({t.name, ".fetch_irwrite"}, 32'(irwrite), 32'd1);
      if (c == 1) check({t.name, ".decode_srcb"}, 32'(alusrcb), 32'(3'b011));
      if (c == 2) begin
        check({t.name, ".aluop"}, 32'(ALUOp), 32'(t.aluop));
        check({t.name, ".alusrca"}, 32'(alusrca), 32'(t.srca));
        check({t.name, ".alusrcb"}, 32'(alusrcb), 32'(t.srcb));
        check({t.name, ".pcsrc"}, 32'(pcsrc), 32'(t.pcsrc));
      end
      if (c == t.cycles - 1) begin
        check({t.name, ".not_fetch_yet"}, 32'(in_fetch()), 32'd0);
        if (t.cycles >= 4) begin
          check({t.name, ".regdst"}, 32'(regdst), 32'(t.regdst));
          check({t.name, ".memtoreg"}, 32'(memtoreg), 32'(t.memtoreg));
        end
      end
      n_rw += int'(regwrite);
      n_mw += int'(memwrite);
      n_pc += int'(pcen);
      n_tr += int'(ovf_trap);
      n_il += int'(illegal);
      tick();
    end
    #1;
    check({t.name, ".back_in_fetch"}, 32'(in_fetch()), 32'd1);
    check({t.name, ".n_regwrite"}, 32'(n_rw), 32'(t.n_rw));
    check({t.name, ".n_memwrite"}, 32'(n_mw), 32'(t.n_mw));
    check({t.name, ".n_pcen"}, 32'(n_pc), 32'(t.n_pcen));
    check({t.name, ".n_ovf_trap"}, 32'(n_tr), 32'(t.n_trap));
    check({t.name, ".n_illegal"}, 32'(n_il), 32'(t.n_ill));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rw, n_mt;

    //       name       op         funct      z  v  cyc aluop     srca   srcb    pcsrc  rd mt rw mw pc tr il
    add_vec("add",     6'b000000, 6'b100000, 0, 0, 4, 5'b00000, 2'b01, 3'b000, 2'b00, 1, 0, 1, 0, 1, 0, 0);
    add_vec("add_ovf", 6'b000000, 6'b100000, 0, 1, 4, 5'b00000, 2'b01, 3'b000, 2'b00, 1, 0, 0, 0, 1, 1, 0);
    add_vec("sub",     6'b000000, 6'b100010, 0, 0, 4, 5'b00001, 2'b01, 3'b000, 2'b00, 1, 0, 1, 0, 1, 0, 0);
    add_vec("sub_ovf", 6'b000000, 6'b100010, 0, 1, 4, 5'b00001, 2'b01, 3'b000, 2'b00, 1, 0, 0, 0, 1, 1, 0);
    add_vec("and_v",   6'b000000, 6'b100100, 0, 1, 4, 5'b11000, 2'b01, 3'b000, 2'b00, 1, 0, 1, 0, 1, 0, 0);
    add_vec("or",      6'b000000, 6'b100101, 0, 0, 4, 5'b11110, 2'b01, 3'b000, 2'b00, 1, 0, 1, 0, 1, 0, 0);
    add_vec("xor",     6'b000000, 6'b100110, 0, 0, 4, 5'b10110, 2'b01, 3'b000, 2'b00, 1, 0, 1, 0, 1, 0, 0);
    add_vec("nor",     6'b000000, 6'b100111, 0, 0, 4, 5'b10001, 2'b01, 3'b000, 2'b00, 1, 0, 1, 0, 1, 0, 0);
    add_vec("slt",     6'b000000, 6'b101010, 0, 0, 4, 5'b00101, 2'b01, 3'b000, 2'b00, 1, 0, 1, 0, 1, 0, 0);
    add_vec("sltu",    6'b000000, 6'b101011, 0, 0, 4, 5'b00111, 2'b01, 3'b000, 2'b00, 1, 0, 1, 0, 1, 0, 0);
    add_vec("sll",     6'b000000, 6'b000000, 0, 0, 4, 5'b01000, 2'b10, 3'b000, 2'b00, 1, 0, 1, 0, 1, 0, 0);
    add_vec("srl",     6'b000000, 6'b000010, 0, 0, 4, 5'b01001, 2'b10, 3'b000, 2'b00, 1, 0, 1, 0, 1, 0, 0);
    add_vec("sra_v",   6'b000000, 6'b000011, 0, 1, 4, 5'b01011, 2'b10, 3'b000, 2'b00, 1, 0, 1, 0, 1, 0, 0);
    add_vec("addi",    6'b001000, 6'b000111, 0, 0, 4, 5'b00000, 2'b01, 3'b010, 2'b00, 0, 0, 1, 0, 1, 0, 0);
    add_vec("addi_ov", 6'b001000, 6'b000111, 0, 1, 4, 5'b00000, 2'b01, 3'b010, 2'b00, 0, 0, 0, 0, 1, 1, 0);
    add_vec("andi_v",  6'b001100, 6'b100000, 0, 1, 4, 5'b11000, 2'b01, 3'b100, 2'b00, 0, 0, 1, 0, 1, 0, 0);
    add_vec("ori",     6'b001101, 6'b100000, 0, 0, 4, 5'b11110, 2'b01, 3'b100, 2'b00, 0, 0, 1, 0, 1, 0, 0);
    add_vec("slti",    6'b001010, 6'b100000, 0, 0, 4, 5'b00101, 2'b01, 3'b010, 2'b00, 0, 0, 1, 0, 1, 0, 0);
    add_vec("lw",      6'b100011, 6'b000000, 0, 0, 5, 5'b00000, 2'b01, 3'b010, 2'b00, 0, 1, 1, 0, 1, 0, 0);
    add_vec("sw",      6'b101011, 6'b000000, 0, 0, 4, 5'b00000, 2'b01, 3'b010, 2'b00, 0, 0, 0, 1, 1, 0, 0);
    add_vec("beq_z1",  6'b000100, 6'b000000, 1, 1, 3, 5'b00001, 2'b01, 3'b000, 2'b01, 0, 0, 0, 0, 2, 0, 0);
    add_vec("beq_z0",  6'b000100, 6'b000000, 0, 0, 3, 5'b00001, 2'b01, 3'b000, 2'b01, 0, 0, 0, 0, 1, 0, 0);
    add_vec("bne_z1",  6'b000101, 6'b000000, 1, 0, 3, 5'b00001, 2'b01, 3'b000, 2'b01, 0, 0, 0, 0, 1, 0, 0);
    add_vec("bne_z0",  6'b000101, 6'b000000, 0, 0, 3, 5'b00001, 2'b01, 3'b000, 2'b01, 0, 0, 0, 0, 2, 0, 0);
    add_vec("j",       6'b000010, 6'b000000, 0, 0, 3, 5'b00000, 2'b00, 3'b000, 2'b10, 0, 0, 0, 0, 2, 0, 0);
    add_vec("ill_op",  6'b111111, 6'b100000, 0, 1, 2, 5'b00000, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0, 1);
    add_vec("ill_fn",  6'b000000, 6'b001000, 0, 1, 2, 5'b00000, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0, 1);

    // Reset state: FETCH decode, handshake strobes held off
    reset = 1'b1; mem_ready = 1'b1; op = '0; funct = '0; z = 1'b0; v = 1'b0;
    #2;
    check("rst.in_fetch", 32'(in_fetch()), 32'd1);
    check("rst.irwrite", 32'(irwrite), 32'd0);
    check("rst.pcen", 32'(pcen), 32'd0);
    check("rst.ovf_trap", 32'(ovf_trap), 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    check("rst.regwrite", 32'(regwrite), 32'd0);
    check("rst.memwrite", 32'(memwrite), 32'd0);
    tick();
    tick();
    check("rst_held.irwrite", 32'(irwrite), 32'd0);
    mem_ready = 1'b0;
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // lw with MEMRD stalled three cycles: 8 cycles total
    n_rw = 0; n_mt = 0;
    op = 6'b100011; funct = '0; z = 1'b0; v = 1'b0;
    for (int c = 0; c < 8; c++) begin
      mem_ready = !(c >= 3 && c <= 5);
      #1;
      if (c >= 3 && c <= 5) begin
        check($sformatf("lw_stall%0d.memread_iord", c), 32'({memread, iord}), 32'(2'b11));
        check($sformatf("lw_stall%0d.regwrite", c), 32'(regwrite), 32'd0);
      end
      if (c == 7) check("lw_stall.not_fetch_yet", 32'(in_fetch()), 32'd0);
      n_rw += int'(regwrite);
      n_mt += int'(regwrite && memtoreg);
      tick();
    end
    #1;
    check("lw_stall.back_in_fetch", 32'(in_fetch()), 32'd1);
    check("lw_stall.n_regwrite", 32'(n_rw), 32'd1);
    check("lw_stall.n_memtoreg_wb", 32'(n_mt), 32'd1);

    // FETCH stalled two cycles, then an add proceeds normally
    mem_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("fetch_stall%0d.irwrite_pcen", c), 32'({irwrite, pcen}), 32'd0);
      check($sformatf("fetch_stall%0d.in_fetch", c), 32'(in_fetch()), 32'd1);
      tick();
    end
    run_vec(vecs[0]);

    // Reset during a MEMWR stall
    op = 6'b101011; funct = '0; mem_ready = 1'b1;
    tick();   // FETCH
    tick();   // DECODE
    tick();   // MEMADR
    mem_ready = 1'b0;
    #1;
    check("sw_rst.memwrite_stall", 32'(memwrite), 32'd1);
    tick();   // still MEMWR
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("sw_rst.memwrite", 32'(memwrite), 32'd0);
    check("sw_rst.in_fetch", 32'(in_fetch()), 32'd1);
    check("sw_rst.irwrite_pcen", 32'({irwrite, pcen}), 32'd0);
    check("sw_rst.regwrite", 32'(regwrite), 32'd0);
    tick();
    check("sw_rst_held.irwrite_pcen", 32'({irwrite, pcen}), 32'd0);
    check("sw_rst_held.in_fetch", 32'(in_fetch()), 32'd1);
    mem_ready = 1'b0;
    reset = 1'b0;
    tick();
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
